// File: rtl/pulse_period_meter_if.sv
// Measurement result bundle from pulse_period_meter to the register interface.
// Master drives the results; slave observes them.
interface pulse_period_meter_if #(
   parameter int CW = 32
);
   logic [CW-1:0] period_o;
   logic [CW-1:0] high_o;
   logic          valid_o;
   logic          timeout_o;
   logic          level_o;

   modport master (
      output period_o,
      output high_o,
      output valid_o,
      output timeout_o,
      output level_o
   );

   modport slave (
      input period_o,
      input high_o,
      input valid_o,
      input timeout_o,
      input level_o
   );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures period and high time of an asynchronous pulse train in clk_i cycles, with stall timeout.
// Results update two edges after sig_i is sampled high; no backpressure, valid_o is a one-cycle strobe.
module pulse_period_meter #(
   parameter int          CW      = 32,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic                 clk_i,
   input  logic                 reset,
   input  logic                 sig_i,
   pulse_period_meter_if.master mon
);

   if ((TIMEOUT < 2) || (64'(TIMEOUT) >= ((64'd1 << CW) - 64'd1))) begin : g_bad_timeout
      $error("pulse_period_meter: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CW - 1");
   end

   localparam logic [CW-1:0] TO = CW'(TIMEOUT);

   typedef enum logic {
      ARM = 1'b0,
      RUN = 1'b1
   } state_t;

   state_t        r_state;
   logic          r_s1;
   logic          r_s2;
   logic          r_s3;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_hcnt;
   logic [CW-1:0] r_hhold;
   logic [CW-1:0] r_period;
   logic [CW-1:0] r_high;
   logic          r_valid;
   logic          r_timeout;

   logic w_rise;
   logic w_fall;

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_state   <= ARM;
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s3      <= 1'b0;
         r_cnt     <= '0;
         r_hcnt    <= '0;
         r_hhold   <= '0;
         r_period  <= '0;
         r_high    <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_s1    <= sig_i;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         r_valid <= 1'b0;

         // Both counters saturate at TIMEOUT so a stalled line can never wrap them.
         if (w_rise) begin
            r_cnt  <= CW'(1);
            r_hcnt <= CW'(1);
         end else begin
            if (r_cnt != TO) begin
               r_cnt <= r_cnt + CW'(1);
            end
            if (r_hcnt != TO) begin
               r_hcnt <= r_hcnt + CW'(1);
            end
         end

         case (r_state)
            ARM: begin
               if (w_rise) begin
                  r_hhold <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               // A rise landing on the saturation cycle is still a valid period.
               if (w_rise) begin
                  r_period  <= r_cnt;
                  r_high    <= r_hhold;
                  r_valid   <= 1'b1;
                  r_timeout <= 1'b0;
                  r_hhold   <= '0;
               end else if (r_cnt == TO) begin
                  r_period  <= '0;
                  r_high    <= '0;
                  r_valid   <= 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= ARM;
               end else if (w_fall) begin
                  r_hhold <= r_hcnt;
               end
            end
         endcase
      end
   end

   assign mon.period_o  = r_period;
   assign mon.high_o    = r_high;
   assign mon.valid_o   = r_valid;
   assign mon.timeout_o = r_timeout;
   assign mon.level_o   = r_s2;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed and randomized pulse trains against a timestamp-based reference of period/high/timeout.
module tb_pulse_period_meter;

   localparam int CW = 16;
   localparam int TO = 500;

   logic clk_i = 1'b0;
   logic reset = 1'b0;
   logic sig_i = 1'b0;

   pulse_period_meter_if #(.CW(CW)) mon_if ();

   pulse_period_meter #(
      .CW      (CW),
      .TIMEOUT (TO)
   ) dut (
      .clk_i (clk_i),
      .reset (reset),
      .sig_i (sig_i),
      .mon   (mon_if)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Reference: absolute edge timestamps of detected rises/falls.
   int       n         = 0;
   int       t_rise    = 0;
   int       t_fall    = 0;
   bit       running   = 1'b0;
   bit       have_fall = 1'b0;
   logic [3:0] hist    = '0;
   int       e_period  = 0;
   int       e_high    = 0;
   bit       e_valid   = 1'b0;
   bit       e_timeout = 1'b0;
   bit       e_level   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic void model_reset();
      hist      = '0;
      running   = 1'b0;
      have_fall = 1'b0;
      e_period  = 0;
      e_high    = 0;
      e_valid   = 1'b0;
      e_timeout = 1'b0;
      e_level   = 1'b0;
   endfunction

   // A level sampled at edge k is seen as an edge event at edge k+2.
   function automatic void model_edge(input logic v);
      bit rise;
      bit fall;
      n++;
      hist    = {hist[2:0], v};
      rise    = hist[2] & ~hist[3];
      fall    = ~hist[2] & hist[3];
      e_valid = 1'b0;
      if (running) begin
         if (rise) begin
            e_period  = n - t_rise;
            e_high    = have_fall ? (t_fall - t_rise) : 0;
            e_valid   = 1'b1;
            e_timeout = 1'b0;
            t_rise    = n;
            have_fall = 1'b0;
         end else if (n - t_rise == TO) begin
            e_period  = 0;
            e_high    = 0;
            e_valid   = 1'b1;
            e_timeout = 1'b1;
            running   = 1'b0;
         end else if (fall) begin
            t_fall    = n;
            have_fall = 1'b1;
         end
      end else if (rise) begin
         running   = 1'b1;
         t_rise    = n;
         have_fall = 1'b0;
      end
      e_level = hist[1];
   endfunction

   task automatic compare_all();
      check("valid",   32'(mon_if.valid_o),   32'(e_valid));
      check("timeout", 32'(mon_if.timeout_o), 32'(e_timeout));
      check("level",   32'(mon_if.level_o),   32'(e_level));
      check("period",  32'(mon_if.period_o),  32'(e_period));
      check("high",    32'(mon_if.high_o),    32'(e_high));
   endtask

   task automatic cyc(input logic v);
      sig_i = v;
      @(posedge clk_i);
      if (reset) model_edge(v);
      else n++;
      @(negedge clk_i);
      compare_all();
   endtask

   task automatic square(input int p, input int h, input int cnt);
      repeat (cnt) begin
         repeat (h) cyc(1'b1);
         repeat (p - h) cyc(1'b0);
      end
   endtask

   initial begin
      int p;
      int h;
      model_reset();
      #1;
      compare_all();
      repeat (3) cyc(1'b0);
      reset = 1'b1;

      // Clean square wave 100/25.
      square(100, 25, 4);
      check("t1_period", 32'(mon_if.period_o), 32'd100);
      check("t1_high",   32'(mon_if.high_o),   32'd25);

      // Fastest legal toggling.
      square(2, 1, 6);
      check("t2_period", 32'(mon_if.period_o), 32'd2);
      check("t2_high",   32'(mon_if.high_o),   32'd1);

      // Stuck high into timeout, then recovery.
      square(100, 25, 2);
      repeat (520) cyc(1'b1);
      check("t3_timeout", 32'(mon_if.timeout_o), 32'd1);
      check("t3_level",   32'(mon_if.level_o),   32'd1);
      check("t3_period",  32'(mon_if.period_o),  32'd0);
      repeat (75) cyc(1'b0);
      square(100, 25, 3);
      check("t3_recover_to", 32'(mon_if.timeout_o), 32'd0);
      check("t3_recover_p",  32'(mon_if.period_o),  32'd100);

      // Period switch 100/50 -> 40/10.
      square(100, 50, 3);
      square(40, 10, 4);
      check("t4_period", 32'(mon_if.period_o), 32'd40);
      check("t4_high",   32'(mon_if.high_o),   32'd10);

      // Rise exactly TIMEOUT edges after the previous one.
      square(TO, 100, 2);
      check("t6_period",  32'(mon_if.period_o),  32'(TO));
      check("t6_timeout", 32'(mon_if.timeout_o), 32'd0);

      // Asynchronous reset in the middle of a high phase.
      repeat (10) cyc(1'b1);
      #2 reset = 1'b0;
      #1 model_reset();
      compare_all();
      check("t5_async_period", 32'(mon_if.period_o), 32'd0);
      @(negedge clk_i);
      repeat (3) cyc(1'b1);
      reset = 1'b1;
      repeat (15) cyc(1'b1);
      repeat (75) cyc(1'b0);
      square(100, 25, 3);
      check("t5_period", 32'(mon_if.period_o), 32'd100);
      check("t5_high",   32'(mon_if.high_o),   32'd25);

      // Random pulse trains.
      repeat (25) begin
         p = int'($urandom_range(80, 2));
         h = int'($urandom_range(p - 1, 1));
         square(p, h, 1);
      end

      // Stuck low into timeout.
      repeat (600) cyc(1'b0);
      check("tlow_timeout", 32'(mon_if.timeout_o), 32'd1);
      check("tlow_level",   32'(mon_if.level_o),   32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Inverse of the clock dividers: measures an incoming pulse train instead of generating one.
- Reports the period and high time of an external digital signal, in clk_i cycles. Typical sources are RC receiver PWM, encoder index and tachometer lines.
- Sits between a board input pin and the register interface.
- Also flags a stalled or absent signal through a timeout.

Parameters:
- CW, 32: counter and output width in bits.
- TIMEOUT, 1000000: cycles without a detected rising edge before timeout. Must satisfy 2 <= TIMEOUT < 2^CW - 1; violating this is an elaboration error.

Ports:
- clk_i  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sig_i  input  1  asynchronous input signal.
- period_o  output  CW  cycles between the last two rising edges.
- high_o  output  CW  cycles sig was high within that period.
- valid_o  output  1  one-cycle strobe when period_o/high_o update.
- timeout_o  output  1  high while no rising edge has occurred within TIMEOUT cycles.
- level_o  output  1  synchronized sig level. Meaningful when timeout_o is high (stuck-high vs stuck-low).

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, all counters 0, synchronizer flops 0, state ARM. Reset mid-measurement discards the partial measurement.
- Synchronizer: 2-flop synchronizer s1->s2, plus s3 = previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - level_o = s2.
- Latency: sig_i high at clock edge k reaches s2 at edge k+1. rise is evaluated during the cycle after k+1. Registered outputs update at edge k+2.
- cnt (period counter):
  - Increments every cycle, saturating at TIMEOUT.
  - On rise: cnt <= 1.
  - At rise, cnt equals the exact cycle distance to the previous rise.
- hcnt (high counter):
  - Increments every cycle; set to 1 on rise.
  - On fall: hhold <= hcnt.
- States:
  - ARM:
    - Wait for rise; fall is ignored.
    - On rise: start cnt/hcnt, clear hhold, go to RUN.
    - No output update in ARM.
  - RUN:
    - On rise: period_o <= cnt; high_o <= hhold; valid_o <= 1 for one cycle; timeout_o <= 0; restart counters; hhold <= 0.
    - If no fall occurred since the previous rise, high_o is 0. This cannot happen for a clean signal, but is the defined result.
    - If cnt reaches TIMEOUT with no rise: timeout_o <= 1; period_o <= 0; high_o <= 0; valid_o <= 1 for that one cycle; go to ARM.
- timeout_o stays 1 until the first full period after recovery. That means two rises: the first re-arms, the second updates the outputs and clears timeout_o.
- Simultaneous events:
  - rise and cnt==TIMEOUT in the same cycle: rise wins (normal measurement, no timeout).
  - rise and fall cannot coincide, by construction.
- Minimum period: 2 cycles (sig toggling every clock) gives period_o=2, high_o=1.
- Width: all counters are CW bits, unsigned. Saturation at TIMEOUT prevents wrap.
- valid_o is never high two cycles in a row, except across a rise immediately following a timeout. That case cannot occur, because ARM does not emit.

Test Plan:
1. Reset released; sig_i square wave, period 100, high 25 (clock-aligned) -> no valid_o on first rise; valid_o on each later rise with period_o=100, high_o=25, timeout_o=0.
2. sig_i toggles every clk_i -> period_o=2, high_o=1 from the second rise onward.
3. TIMEOUT=500; run period 100, then hold sig_i high -> exactly 500 cycles after the last rise detection: timeout_o=1, valid_o pulse, period_o=0, high_o=0, level_o=1. Resume period 100 -> timeout_o clears with period_o=100 on the second rise.
4. Period switches from 100/50 to 40/10 -> the first post-switch valid_o reports the actual mixed interval; subsequent ones report 40/10.
5. Assert reset mid-high-phase for 3 cycles -> all outputs 0 immediately, without waiting for a clock edge. After release, the first rise produces no valid_o; the second reports correct values.
6. Rise detected in the same cycle cnt hits TIMEOUT -> valid_o with period_o=TIMEOUT, timeout_o stays 0.
